ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand and result width; legal values 16, 32 and 64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request from the execute stage.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 op  input  3  RV M-extension funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 rs1_data  input  XLEN  dividend or multiplicand.
REQ-008 rs2_data  input  XLEN  divisor or multiplier.
REQ-009 flush  input  1  pipeline kill; abandons any in-flight operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  operation result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states are IDLE, CALC and DONE; in_ready = (state==IDLE).
REQ-015 An accept occurs when in_valid && in_ready && !flush; it registers op and operands and moves to CALC, or to DONE for the special cases in REQ-019/020.
REQ-016 CALC runs exactly XLEN iterations, using a counter of width clog2(XLEN+1): radix-2 shift-add for multiply, restoring shift-subtract for divide.
REQ-017 Signed ops take absolute values before iterating and fix the sign after: MULHSU treats only rs1 as signed; remainder sign follows the dividend.
REQ-018 Normal latency: accept at edge T, out_valid high after edge T+XLEN+1.
REQ-019 Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1; these reach DONE one cycle after accept.
REQ-020 Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV gives rs1 and REM gives 0, with one-cycle latency.
REQ-021 In DONE, out_valid=1 and result is held stable until out_valid && out_ready; the FSM then returns to IDLE on that edge.
REQ-022 The unit holds one operation at a time; the next accept happens no earlier than the cycle after the handshake.
REQ-023 flush takes priority over everything: the next state is IDLE, out_valid is low the next cycle, and no accept occurs that cycle.
REQ-024 MUL returns the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU return the high XLEN bits.

Reset
REQ-025 With rst high at a clock edge: state=IDLE, counter=0, out_valid=0, busy=0, result=0. in_ready=1 from the first cycle after reset.
REQ-026 Reset during CALC or DONE discards the operation without emitting a result.

Configuration
REQ-027 Macro MULDIV_DIV_EN: when defined, ops 4-7 behave as specified above.
REQ-028 When MULDIV_DIV_EN is undefined, no divider logic is synthesised, and ops 4-7 complete with one-cycle latency with result=0.

Structure
REQ-029 The op encodings (MD_MUL to MD_REMU), the FSM state encodings and XLEN-derived width constants belong in the shared defines file alongside RegBus.
REQ-030 The iterative datapath (accumulator, shift registers, counter) is one sub-module, muldiv_iter; ex_muldiv contains the FSM, sign handling, special cases and handshake.

Verification
REQ-031 MUL with rs1=7, rs2=-3 (0xFFFFFFFD), XLEN=32 -> result 0xFFFFFFEB, out_valid after 33 cycles.
REQ-032 MULHU with 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-033 DIV with -7/2 -> 0xFFFFFFFD; REM with -7/2 -> 0xFFFFFFFF; DIVU with 100/0 -> 0xFFFFFFFF, one-cycle latency.
REQ-034 DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, no CALC cycles.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; pulse out_ready -> IDLE next cycle.
REQ-036 Assert flush at CALC iteration 10, with in_valid also high -> IDLE next cycle, no out_valid, request not accepted; a following MUL with 3*4 gives 12.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: op codes,
// FSM encodings and width helpers. Divider support is gated by MULDIV_DIV_EN.
package ex_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [XLEN_DEFAULT-1:0] RegBus;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative datapath: radix-2 shift-add multiply and, when MULDIV_DIV_EN is
// defined, restoring shift-subtract divide on unsigned magnitudes.
module muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_run,
`ifdef MULDIV_DIV_EN
    input  logic            i_is_div,
`endif
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo,
    output logic            o_done
);

    localparam int CW = cnt_width(XLEN);
    localparam logic [CW-1:0] CNT_END = CW'(XLEN);

    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0] w_lo_nxt;
`ifdef MULDIV_DIV_EN
    logic            r_div;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
`endif

    // One iteration step; r_acc:r_lo holds product (mul) or remainder:quotient (div)
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
        w_acc_nxt = w_sum[XLEN:1];
        w_lo_nxt  = {w_sum[0], r_lo[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
        w_shift   = {r_acc, r_lo[XLEN-1]};
        w_diff    = w_shift - {1'b0, r_b};
        if (r_div) begin
            if (w_diff[XLEN] == 1'b0) begin
                w_acc_nxt = w_diff[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_shift[XLEN-1:0];
                w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = w_sum[XLEN:1];
        end
`endif
    end

    // Operand load and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {XLEN{1'b0}};
            r_lo  <= {XLEN{1'b0}};
            r_b   <= {XLEN{1'b0}};
            r_cnt <= {CW{1'b0}};
`ifdef MULDIV_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_load) begin
            r_acc <= {XLEN{1'b0}};
            r_lo  <= i_a;
            r_b   <= i_b;
            r_cnt <= {CW{1'b0}};
`ifdef MULDIV_DIV_EN
            r_div <= i_is_div;
`endif
        end else if (i_run && (r_cnt != CNT_END)) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_hi   = r_acc;
    assign o_lo   = r_lo;
    assign o_done = (r_cnt == CNT_END);

endmodule

// File: rtl/ex_muldiv.sv
// RV M-extension multiply/divide unit: FSM, sign handling, special cases and
// handshake. Define MULDIV_DIV_EN to build the divider (ops 4-7).
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    md_state_e         r_state;
    md_state_e         w_next;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;
    logic              w_accept;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic              w_done;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_final;

    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_a_neg  = rs1_data[XLEN-1] &&
                      ((op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM));
    assign w_b_neg  = rs2_data[XLEN-1] &&
                      ((op == MD_MULH) || (op == MD_DIV) || (op == MD_REM));
    // Remainder sign follows the dividend; everything else uses the XOR of signs
    assign w_neg    = (op[2] && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_abs_a  = w_a_neg ? ({XLEN{1'b0}} - rs1_data) : rs1_data;
    assign w_abs_b  = w_b_neg ? ({XLEN{1'b0}} - rs2_data) : rs2_data;

`ifdef MULDIV_DIV_EN
    logic w_div_zero;
    logic w_ovf;
    assign w_div_zero = op[2] && (rs2_data == {XLEN{1'b0}});
    assign w_ovf      = ((op == MD_DIV) || (op == MD_REM)) &&
                        (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == {XLEN{1'b1}});
    assign w_special  = w_div_zero || w_ovf;

    // Results that bypass the iterative datapath
    always_comb begin
        w_special_val = {XLEN{1'b0}};
        if (w_div_zero) begin
            w_special_val = op[1] ? rs1_data : {XLEN{1'b1}};
        end else begin
            w_special_val = op[1] ? {XLEN{1'b0}} : rs1_data;
        end
    end
`else
    assign w_special     = op[2];
    assign w_special_val = {XLEN{1'b0}};
`endif

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept && !w_special),
        .i_run    (r_state == ST_CALC),
`ifdef MULDIV_DIV_EN
        .i_is_div (op[2]),
`endif
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_hi),
        .o_lo     (w_lo),
        .o_done   (w_done)
    );

    assign w_prod = r_neg ? ({(2*XLEN){1'b0}} - {w_hi, w_lo}) : {w_hi, w_lo};

    // Sign-corrected result selection at the end of CALC
    always_comb begin
        w_final = {XLEN{1'b0}};
        case (r_op)
            MD_MUL:    w_final = w_prod[XLEN-1:0];
            MD_MULH,
            MD_MULHSU,
            MD_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
            MD_DIV,
            MD_DIVU:   w_final = r_neg ? ({XLEN{1'b0}} - w_lo) : w_lo;
            MD_REM,
            MD_REMU:   w_final = r_neg ? ({XLEN{1'b0}} - w_hi) : w_hi;
`endif
            default:   w_final = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w_next = w_special ? ST_DONE : ST_CALC;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_done) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operation context and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= MD_MUL;
            r_neg    <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_op     <= op;
            r_neg    <= w_neg;
            r_result <= w_special ? w_special_val : r_result;
        end else if ((r_state == ST_CALC) && w_done && !flush) begin
            r_result <= w_final;
        end else begin
            r_result <= r_result;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (XLEN=32); divide expectations
// follow MULDIV_DIV_EN.
module tb_ex_muldiv;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure edges after accept until out_valid, then handshake
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_result"}, {32'd0, result}, {32'd0, exp});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        int n;
        logic seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Multiply family
        do_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulh_ff", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("mulh_min_2", OP_MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 33);

        // Divide family (zero result, single cycle when the divider is absent)
`ifdef MULDIV_DIV_EN
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        do_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
        do_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
`else
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 0);
        do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 0);
        do_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'd0, 0);
        do_op("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd0, 0);
`endif

        // Back-pressure: result held while out_ready is low
        @(negedge clk);
        op = OP_MUL; rs1_data = 32'd5; rs2_data = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", 64'(n), 64'd33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_result", {32'd0, result}, 64'd30);
            check("bp_hold_flags", {62'd0, in_ready, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", {61'd0, in_ready, out_valid, busy}, 64'd4);

        // Flush at iteration 10 with a competing request
        @(negedge clk);
        op = OP_MUL; rs1_data = 32'h1234; rs2_data = 32'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_pre_busy", {63'd0, busy}, 64'd1);
        flush = 1'b1; in_valid = 1'b1; rs1_data = 32'd9; rs2_data = 32'd9;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("flush_no_result", {63'd0, seen}, 64'd0);
        do_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 33);

        // Reset in the middle of CALC discards the operation
        @(negedge clk);
        op = OP_MUL; rs1_data = 32'h55; rs2_data = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_calc_state", {61'd0, in_ready, out_valid, busy}, 64'd4);
        check("rst_calc_result", {32'd0, result}, 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        check("rst_calc_no_result", {63'd0, seen}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
